// File: rtl/pulse_sched_pkg.sv
// Shared types for the pulse-train command scheduler: command record, FSM states, tick rate.
package pulse_sched_pkg;

    localparam int TICKS_PER_US = 48;

    typedef struct packed {
        logic [47:0] DDS_freq;
        logic [47:0] DDS_dfreq;
        logic [31:0] DDS_drate;
        logic [47:0] TIME_START;
        logic [15:0] N_impuls;
        logic [1:0]  TYPE;
        logic [31:0] Ti;
        logic [31:0] Tp;
        logic [31:0] Tb1;
        logic [31:0] Tb2;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, CHECK, LOAD, WAIT_ST, WAIT_DN, DROP} sched_state_t;

endpackage

// File: rtl/pulse_cmd_scheduler_if.sv
// Host push bus and master load port of the scheduler.
// The master modport is the host/board side; the slave modport is the scheduler.
interface pulse_cmd_scheduler_if;

    logic        H_WR;
    logic [47:0] H_DDS_freq;
    logic [47:0] H_DDS_dfreq;
    logic [31:0] H_DDS_drate;
    logic [47:0] H_TIME_START;
    logic [15:0] H_N_impuls;
    logic [1:0]  H_TYPE;
    logic [31:0] H_Ti;
    logic [31:0] H_Tp;
    logic [31:0] H_Tb1;
    logic [31:0] H_Tb2;

    logic        WR_DATA;
    logic [47:0] MEM_DDS_freq;
    logic [47:0] MEM_DDS_dfreq;
    logic [31:0] MEM_DDS_drate;
    logic [47:0] MEM_TIME_START;
    logic [15:0] MEM_N_impuls;
    logic [1:0]  MEM_TYPE;
    logic [31:0] MEM_Ti;
    logic [31:0] MEM_Tp;
    logic [31:0] MEM_Tb1;
    logic [31:0] MEM_Tb2;

    modport master (
        output H_WR, H_DDS_freq, H_DDS_dfreq, H_DDS_drate, H_TIME_START, H_N_impuls,
               H_TYPE, H_Ti, H_Tp, H_Tb1, H_Tb2,
        input  WR_DATA, MEM_DDS_freq, MEM_DDS_dfreq, MEM_DDS_drate, MEM_TIME_START,
               MEM_N_impuls, MEM_TYPE, MEM_Ti, MEM_Tp, MEM_Tb1, MEM_Tb2
    );

    modport slave (
        input  H_WR, H_DDS_freq, H_DDS_dfreq, H_DDS_drate, H_TIME_START, H_N_impuls,
               H_TYPE, H_Ti, H_Tp, H_Tb1, H_Tb2,
        output WR_DATA, MEM_DDS_freq, MEM_DDS_dfreq, MEM_DDS_drate, MEM_TIME_START,
               MEM_N_impuls, MEM_TYPE, MEM_Ti, MEM_Tp, MEM_Tb1, MEM_Tb2
    );

endinterface

// File: rtl/pulse_cmd_scheduler_cmd_fifo.sv
// Synchronous command FIFO with a registered head read; the head register tracks the read
// pointer every cycle, so it is valid one cycle after an entry lands or a pop retires.
module cmd_fifo
    import pulse_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   push,
    input  logic                   pop,
    input  cmd_t                   din,
    output cmd_t                   head,
    output logic [$clog2(DEPTH):0] cnt,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_pop;

    assign do_pop = pop && !empty;
    assign full   = (cnt == (AW+1)'(DEPTH));
    assign empty  = (cnt == '0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            head   <= '0;
        end else begin
            head <= mem[rd_ptr];
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pulse_cmd_scheduler.sv
// Queues host pulse-train commands and loads them one at a time into the pulse-train master.
// Optional late-command dropping is built when SCHED_LATE_CHECK_EN is defined.
module pulse_cmd_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int LEAD_TICKS = 10 * TICKS_PER_US
) (
    input  logic                   CLK,
    input  logic                   RESET,
    pulse_cmd_scheduler_if.slave   bus,
    input  logic [47:0]            SYS_TIME,
    input  logic                   MASTER_BUSY,
    input  logic                   OVF_CLR,
    output logic [$clog2(DEPTH):0] FIFO_CNT,
    output logic                   FULL,
    output logic                   EMPTY,
    output logic                   OVF,
    output logic [15:0]            LATE_CNT
);

    sched_state_t state;
    cmd_t         h_cmd, head, ld;
    logic         push, pop, late, busy_q;

    assign h_cmd = '{DDS_freq:   bus.H_DDS_freq,   DDS_dfreq: bus.H_DDS_dfreq,
                     DDS_drate:  bus.H_DDS_drate,  TIME_START: bus.H_TIME_START,
                     N_impuls:   bus.H_N_impuls,   TYPE:      bus.H_TYPE,
                     Ti:         bus.H_Ti,         Tp:        bus.H_Tp,
                     Tb1:        bus.H_Tb1,        Tb2:       bus.H_Tb2};

    // A push into a full FIFO still succeeds when the head retires on the same edge.
    assign pop  = (state == LOAD) || (state == DROP);
    assign push = bus.H_WR && (!FULL || pop);

    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (push),
        .pop   (pop),
        .din   (h_cmd),
        .head  (head),
        .cnt   (FIFO_CNT),
        .full  (FULL),
        .empty (EMPTY)
    );

    always_ff @(posedge CLK) begin
        if (RESET)
            OVF <= 1'b0;
        else if (bus.H_WR && FULL && !pop)
            OVF <= 1'b1;
        else if (OVF_CLR)
            OVF <= 1'b0;
    end

`ifdef SCHED_LATE_CHECK_EN
    assign late = {1'b0, head.TIME_START} < ({1'b0, SYS_TIME} + 49'(LEAD_TICKS));

    always_ff @(posedge CLK) begin
        if (RESET)
            LATE_CNT <= '0;
        else if (state == DROP && LATE_CNT != 16'hFFFF)
            LATE_CNT <= LATE_CNT + 16'd1;
    end
`else
    assign late     = 1'b0;
    assign LATE_CNT = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            bus.WR_DATA <= 1'b0;
            ld          <= '0;
            busy_q      <= 1'b0;
        end else begin
            busy_q      <= MASTER_BUSY;
            bus.WR_DATA <= 1'b0;
            case (state)
                IDLE:    if (!EMPTY && !MASTER_BUSY) state <= CHECK;
                CHECK: begin
                    if (late) begin
                        state <= DROP;
                    end else begin
                        ld          <= head;
                        bus.WR_DATA <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD:    state <= WAIT_ST;
                // The master may start early (busy rising) before SYS_TIME reaches the start.
                WAIT_ST: if (SYS_TIME >= ld.TIME_START || (MASTER_BUSY && !busy_q)) state <= WAIT_DN;
                WAIT_DN: if (!MASTER_BUSY) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.MEM_DDS_freq   = ld.DDS_freq;
    assign bus.MEM_DDS_dfreq  = ld.DDS_dfreq;
    assign bus.MEM_DDS_drate  = ld.DDS_drate;
    assign bus.MEM_TIME_START = ld.TIME_START;
    assign bus.MEM_N_impuls   = ld.N_impuls;
    assign bus.MEM_TYPE       = ld.TYPE;
    assign bus.MEM_Ti         = ld.Ti;
    assign bus.MEM_Tp         = ld.Tp;
    assign bus.MEM_Tb1        = ld.Tb1;
    assign bus.MEM_Tb2        = ld.Tb2;

endmodule

// File: tb/tb_pulse_cmd_scheduler.sv
// Bench for pulse_cmd_scheduler: directed scenarios plus randomized bursts against a
// queue scoreboard and a behavioural pulse-train master.
module tb_pulse_cmd_scheduler;
    import pulse_sched_pkg::*;

    localparam int DEPTH = 8;
    localparam int LEAD  = 480;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [47:0] sys_time = 48'd100000;
    logic        man_busy = 1'b0, emu_busy = 1'b0, emu_en = 1'b0, OVF_CLR = 1'b0;
    logic        MASTER_BUSY;
    logic [3:0]  FIFO_CNT;
    logic        FULL, EMPTY, OVF;
    logic [15:0] LATE_CNT;

    int          checks = 0, errors = 0;
    cmd_t        sb[$];
    int          loads = 0, trains_done = 0, emu_dur = 0, emu_left = 0;
    logic        pend = 1'b0, wr_prev = 1'b0;
    logic [47:0] pstart = '0, ts;
    cmd_t        c;
    int          l0, t0, npush, late_exp = 0;

    pulse_cmd_scheduler_if bus();

    assign MASTER_BUSY = emu_en ? emu_busy : man_busy;

    pulse_cmd_scheduler #(.DEPTH(DEPTH), .LEAD_TICKS(LEAD)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .bus         (bus),
        .SYS_TIME    (sys_time),
        .MASTER_BUSY (MASTER_BUSY),
        .OVF_CLR     (OVF_CLR),
        .FIFO_CNT    (FIFO_CNT),
        .FULL        (FULL),
        .EMPTY       (EMPTY),
        .OVF         (OVF),
        .LATE_CNT    (LATE_CNT)
    );

    always #10 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic cmd_t rand_cmd(input logic [47:0] start);
        cmd_t        r;
        logic [63:0] a, b;
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()};
        r.DDS_freq   = a[47:0];
        r.DDS_dfreq  = b[47:0];
        r.DDS_drate  = $urandom();
        r.TIME_START = start;
        r.N_impuls   = a[63:48];
        r.TYPE       = b[49:48];
        r.Ti         = $urandom();
        r.Tp         = $urandom();
        r.Tb1        = $urandom();
        r.Tb2        = $urandom();
        return r;
    endfunction

    // Called at a negedge; holds H_WR for one cycle. acc = model says the entry is kept.
    task automatic push(input cmd_t p, input bit acc);
        bus.H_WR         = 1'b1;
        bus.H_DDS_freq   = p.DDS_freq;
        bus.H_DDS_dfreq  = p.DDS_dfreq;
        bus.H_DDS_drate  = p.DDS_drate;
        bus.H_TIME_START = p.TIME_START;
        bus.H_N_impuls   = p.N_impuls;
        bus.H_TYPE       = p.TYPE;
        bus.H_Ti         = p.Ti;
        bus.H_Tp         = p.Tp;
        bus.H_Tb1        = p.Tb1;
        bus.H_Tb2        = p.Tb2;
        if (acc) sb.push_back(p);
        @(negedge CLK);
        bus.H_WR = 1'b0;
    endtask

    task automatic wait_wr(input string tag, input int lim);
        int n = 0;
        while (bus.WR_DATA !== 1'b1 && n < lim) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, bus.WR_DATA, 1);
    endtask

    task automatic wait_drain(input string tag, input int lim);
        int n = 0;
        while ((sb.size() != 0 || pend || emu_busy) && n < lim) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, n < lim, 1);
        repeat (4) @(negedge CLK);
    endtask

    // Load monitor, system time and pulse-train master model, in a fixed order per cycle.
    initial begin : mon
        cmd_t e;
        forever begin
            @(negedge CLK);
            if (bus.WR_DATA === 1'b1) begin
                chk("wr_pulse", wr_prev, 0);
                chk("ld_idle", MASTER_BUSY, 0);
                if (emu_en) chk("ld_prev_done", {emu_busy, pend}, 0);
                chk("ld_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("ld_freq",  bus.MEM_DDS_freq,   e.DDS_freq);
                    chk("ld_dfreq", bus.MEM_DDS_dfreq,  e.DDS_dfreq);
                    chk("ld_drate", bus.MEM_DDS_drate,  e.DDS_drate);
                    chk("ld_start", bus.MEM_TIME_START, e.TIME_START);
                    chk("ld_nimp",  bus.MEM_N_impuls,   e.N_impuls);
                    chk("ld_type",  bus.MEM_TYPE,       e.TYPE);
                    chk("ld_ti",    bus.MEM_Ti,         e.Ti);
                    chk("ld_tp",    bus.MEM_Tp,         e.Tp);
                    chk("ld_tb1",   bus.MEM_Tb1,        e.Tb1);
                    chk("ld_tb2",   bus.MEM_Tb2,        e.Tb2);
                end
                loads++;
                pend   = emu_en;
                pstart = bus.MEM_TIME_START;
            end
            wr_prev  = bus.WR_DATA;
            sys_time = sys_time + 48'd1;
            if (!emu_en) begin
                pend     = 1'b0;
                emu_busy = 1'b0;
            end else if (emu_busy) begin
                emu_left--;
                if (emu_left == 0) begin
                    emu_busy = 1'b0;
                    trains_done++;
                end
            end else if (pend && sys_time >= pstart) begin
                emu_busy = 1'b1;
                pend     = 1'b0;
                emu_left = (emu_dur > 0) ? emu_dur : int'($urandom_range(1, 100));
            end
        end
    end

    initial begin
        bus.H_WR = 1'b0;
        bus.H_DDS_freq = '0; bus.H_DDS_dfreq = '0; bus.H_DDS_drate = '0;
        bus.H_TIME_START = '0; bus.H_N_impuls = '0; bus.H_TYPE = '0;
        bus.H_Ti = '0; bus.H_Tp = '0; bus.H_Tb1 = '0; bus.H_Tb2 = '0;
        repeat (3) @(negedge CLK);

        chk("rst_wr",    bus.WR_DATA, 0);
        chk("rst_mem_f", bus.MEM_DDS_freq, 0);
        chk("rst_mem_t", bus.MEM_TIME_START, 0);
        chk("rst_cnt",   FIFO_CNT, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_full",  FULL, 0);
        chk("rst_ovf",   OVF, 0);
        chk("rst_late",  LATE_CNT, 0);
        RESET = 1'b0;
        @(negedge CLK);

        // Single command into an empty queue with the master idle: strobe 3 cycles after H_WR.
        c = rand_cmd(sys_time + 48'd1000);
        push(c, 1'b1);
        chk("t1_wr_c1", bus.WR_DATA, 0);
        @(negedge CLK); chk("t1_wr_c2", bus.WR_DATA, 0);
        @(negedge CLK); chk("t1_wr_c3", bus.WR_DATA, 1);
        @(negedge CLK); chk("t1_wr_c4", bus.WR_DATA, 0);
        chk("t1_mem_hold", bus.MEM_N_impuls, c.N_impuls);
        chk("t1_cnt", FIFO_CNT, 0);
        repeat (1010) @(negedge CLK);

        // Three commands, master busy 200 cycles from each start.
        emu_en = 1'b1; emu_dur = 200;
        l0 = loads; t0 = trains_done;
        ts = sys_time + 48'd1000;
        for (int k = 0; k < 3; k++) begin
            push(rand_cmd(ts), 1'b1);
            ts = ts + 48'd800;
        end
        wait_drain("t2_drain", 5000);
        chk("t2_loads", loads - l0, 3);
        chk("t2_trains", trains_done - t0, 3);
        emu_en = 1'b0;

        // Command whose start is closer than the lead time.
        @(negedge CLK);
        l0 = loads;
        c = rand_cmd(sys_time + 48'd100);
`ifdef SCHED_LATE_CHECK_EN
        push(c, 1'b0);
        late_exp = 1;
        repeat (20) @(negedge CLK);
        chk("t4_noload", loads - l0, 0);
`else
        push(c, 1'b1);
        repeat (20) @(negedge CLK);
        chk("t4_loaded", loads - l0, 1);
        repeat (100) @(negedge CLK);
`endif
        chk("t4_late_cnt", LATE_CNT, late_exp);
        chk("t4_empty", EMPTY, 1);

        // Randomized bursts with random pacing and train lengths.
        emu_en = 1'b1; emu_dur = 0;
        l0 = loads; npush = 0;
        ts = sys_time + 48'd1000;
        for (int b = 0; b < 4; b++) begin
            if (ts < sys_time + 48'd1000) ts = sys_time + 48'd1000;
            for (int i = 0; i < 5; i++) begin
                push(rand_cmd(ts), 1'b1);
                npush++;
                ts = ts + 48'(700 + $urandom_range(0, 400));
                repeat ($urandom_range(0, 3)) @(negedge CLK);
            end
            wait_drain("rnd_drain", 20000);
        end
        chk("rnd_loads", loads - l0, npush);
        chk("rnd_cnt", FIFO_CNT, 0);
        chk("rnd_empty", EMPTY, 1);
        chk("rnd_late", LATE_CNT, late_exp);
        chk("rnd_ovf", OVF, 0);
        emu_en = 1'b0;

        // Fill past capacity with the master held busy.
        man_busy = 1'b1;
        @(negedge CLK);
        ts = sys_time + 48'd5000;
        for (int i = 0; i < DEPTH; i++) push(rand_cmd(ts), sb.size() < DEPTH);
        chk("t3_full", FULL, 1);
        chk("t3_cnt8", FIFO_CNT, DEPTH);
        chk("t3_ovf0", OVF, 0);
        push(rand_cmd(ts), sb.size() < DEPTH);
        chk("t3_ovf", OVF, 1);
        chk("t3_cnt9", FIFO_CNT, DEPTH);
        OVF_CLR = 1'b1;
        push(rand_cmd(ts), sb.size() < DEPTH);
        OVF_CLR = 1'b0;
        chk("t3_ovf_clr_push", OVF, 1);
        OVF_CLR = 1'b1;
        @(negedge CLK);
        OVF_CLR = 1'b0;
        chk("t3_ovf_clr", OVF, 0);

        // Push landing on the same edge as the pop of a full queue.
        man_busy = 1'b0;
        wait_wr("t5_load", 10);
        push(rand_cmd(ts), 1'b1);
        chk("t5_cnt", FIFO_CNT, DEPTH);
        chk("t5_full", FULL, 1);
        chk("t5_ovf", OVF, 0);

        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        sb.delete();

        // Reset while the master runs a train with two commands still queued.
        ts = sys_time + 48'd1000;
        push(rand_cmd(ts), 1'b1);
        push(rand_cmd(ts + 48'd2000), 1'b1);
        push(rand_cmd(ts + 48'd3000), 1'b1);
        wait_wr("t6_load", 10);
        @(negedge CLK);
        man_busy = 1'b1;
        repeat (3) @(negedge CLK);
        chk("t6_cnt_pre", FIFO_CNT, 2);
        l0 = loads;
        RESET = 1'b1;
        @(negedge CLK);
        chk("t6_wr",    bus.WR_DATA, 0);
        chk("t6_mem_f", bus.MEM_DDS_freq, 0);
        chk("t6_mem_t", bus.MEM_TIME_START, 0);
        chk("t6_cnt",   FIFO_CNT, 0);
        chk("t6_empty", EMPTY, 1);
        chk("t6_full",  FULL, 0);
        chk("t6_ovf",   OVF, 0);
        chk("t6_late",  LATE_CNT, 0);
        RESET = 1'b0;
        man_busy = 1'b0;
        sb.delete();
        repeat (40) @(negedge CLK);
        chk("t6_noload", loads - l0, 0);
        chk("t6_cnt_post", FIFO_CNT, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
